// File: rtl/register_file_64_if.sv
// Register file port bundle: two read indices, one write-back port,
// the two operand outputs and the committed-write counter.
interface register_file_64_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
);

   logic [ADDR_WIDTH-1:0] rs1;
   logic [ADDR_WIDTH-1:0] rs2;
   logic [ADDR_WIDTH-1:0] rd;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  reg_write;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;
   logic [15:0]           write_count;

   modport master (
      output rs1,
      output rs2,
      output rd,
      output write_data,
      output reg_write,
      input  read_data1,
      input  read_data2,
      input  write_count
   );

   modport slave (
      input  rs1,
      input  rs2,
      input  rd,
      input  write_data,
      input  reg_write,
      output read_data1,
      output read_data2,
      output write_count
   );

endinterface

// File: rtl/register_file_64.sv
// Integer register file: 32 x DATA_WIDTH, x0 hardwired to zero,
// two combinational read ports with optional write-to-read forwarding.
module register_file_64 #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter bit BYPASS     = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   register_file_64_if.slave rf
);

   localparam int NREGS = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t       regs_q [NREGS];
   word_t       regs_d [NREGS];
   logic [15:0] write_count_q;
   logic [15:0] write_count_d;
   logic        wr_en;
   word_t       rd1_val;
   word_t       rd2_val;

   assign wr_en = rf.reg_write && (rf.rd != '0);

   always_comb begin
      regs_d        = regs_q;
      write_count_d = write_count_q;
      if (wr_en) begin
         regs_d[rf.rd] = rf.write_data;
         if (write_count_q != 16'hFFFF) begin
            write_count_d = write_count_q + 16'd1;
         end
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         write_count_q <= write_count_d;
      end
   end

   // Reset gates the outputs so a pending write cannot leak through bypass.
   always_comb begin
      rd1_val = regs_q[rf.rs1];
      if (BYPASS && wr_en && (rf.rs1 == rf.rd)) begin
         rd1_val = rf.write_data;
      end
      if (!rst_n || (rf.rs1 == '0)) begin
         rd1_val = '0;
      end
   end

   always_comb begin
      rd2_val = regs_q[rf.rs2];
      if (BYPASS && wr_en && (rf.rs2 == rf.rd)) begin
         rd2_val = rf.write_data;
      end
      if (!rst_n || (rf.rs2 == '0)) begin
         rd2_val = '0;
      end
   end

   assign rf.read_data1  = rd1_val;
   assign rf.read_data2  = rd2_val;
   assign rf.write_count = write_count_q;

endmodule

// File: tb/tb_register_file_64.sv
// Bench for register_file_64: one forwarding and one non-forwarding
// instance driven in lockstep and checked against an array model.
module tb_register_file_64;

   localparam int DW = 64;
   localparam int AW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   register_file_64_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();
   register_file_64_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nif ();

   register_file_64 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bif)
   );

   register_file_64 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (nif)
   );

   always #5 clk = ~clk;

   logic [63:0] model [32];
   int unsigned wcount;
   int          nvec;
   int          nerr;

   task automatic apply(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [63:0] wd,
                        input logic we);
      bif.rs1 = a;  nif.rs1 = a;
      bif.rs2 = b;  nif.rs2 = b;
      bif.rd  = d;  nif.rd  = d;
      bif.write_data = wd;  nif.write_data = wd;
      bif.reg_write  = we;  nif.reg_write  = we;
   endtask

   function automatic logic [63:0] exp_read(input logic [4:0] rs, input bit byp);
      if (!rst_n || rs == 5'd0) return 64'h0;
      if (byp && bif.reg_write && bif.rd != 5'd0 && bif.rd == rs)
         return bif.write_data;
      return model[rs];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
      wcount = 0;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n && bif.reg_write && bif.rd != 5'd0) begin
         model[bif.rd] = bif.write_data;
         if (wcount < 65535) wcount++;
      end
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         apply(5'd0, 5'd0, 5'(i), {32'(i), 32'hC0DE_0000 | 32'(i)}, 1'b1);
         step();
      end
      @(negedge clk);
      apply(5'd3, 5'd3, 5'd3, 64'h1234_5678_9ABC_DEF0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if (bif.read_data1 !== 64'h0 || bif.read_data2 !== 64'h0) begin
         nerr++;
         $display("FAIL reset_bypass got=%h/%h exp=0", bif.read_data1, bif.read_data2);
      end
      for (int i = 1; i < 32; i++) begin
         apply(5'(i), 5'(32 - i), 5'(i), 64'hFFFF, 1'b1);
         #1;
         nvec++;
         if (bif.read_data1 !== 64'h0 || bif.read_data2 !== 64'h0 ||
             nif.read_data1 !== 64'h0 || nif.read_data2 !== 64'h0) begin
            nerr++;
            $display("FAIL reset_read rs=%0d got=%h %h %h %h exp=0", i,
                     bif.read_data1, bif.read_data2, nif.read_data1, nif.read_data2);
         end
      end
      clear_model();
      nvec++;
      if (bif.write_count !== 16'h0 || nif.write_count !== 16'h0) begin
         nerr++;
         $display("FAIL reset_count got=%h/%h exp=0", bif.write_count, nif.write_count);
      end
      @(negedge clk);
      apply(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
      rst_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         apply(5'(i), 5'(i), 5'd0, 64'h0, 1'b0);
         #1;
         nvec++;
         if (nif.read_data1 !== 64'h0 || bif.read_data2 !== 64'h0) begin
            nerr++;
            $display("FAIL reset_cleared rs=%0d got=%h/%h exp=0", i,
                     nif.read_data1, bif.read_data2);
         end
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      apply(5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      step();
      apply(5'd0, 5'd0, 5'd6, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
      step();
      apply(5'd5, 5'd6, 5'd0, 64'h0, 1'b0);
      #1;
      nvec++;
      if (bif.read_data1 !== 64'hFFFF_FFFF_FFFF_FFFF ||
          nif.read_data1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         nerr++;
         $display("FAIL basic_x5 got=%h/%h exp=all-ones", bif.read_data1, nif.read_data1);
      end
      nvec++;
      if (bif.read_data2 !== 64'hAAAA_AAAA_AAAA_AAAA ||
          nif.read_data2 !== 64'hAAAA_AAAA_AAAA_AAAA) begin
         nerr++;
         $display("FAIL basic_x6 got=%h/%h exp=aaaa..", bif.read_data2, nif.read_data2);
      end
      nvec++;
      if (bif.write_count !== 16'd2 || nif.write_count !== 16'd2) begin
         nerr++;
         $display("FAIL basic_count got=%0d/%0d exp=2", bif.write_count, nif.write_count);
      end
   endtask

   task automatic test_x0();
      apply(5'd0, 5'd0, 5'd0, 64'h1, 1'b1);
      #1;
      nvec++;
      if (bif.read_data1 !== 64'h0 || bif.read_data2 !== 64'h0 ||
          nif.read_data1 !== 64'h0 || nif.read_data2 !== 64'h0) begin
         nerr++;
         $display("FAIL x0_during got=%h %h %h %h exp=0",
                  bif.read_data1, bif.read_data2, nif.read_data1, nif.read_data2);
      end
      step();
      apply(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
      #1;
      nvec++;
      if (bif.read_data1 !== 64'h0 || nif.read_data2 !== 64'h0) begin
         nerr++;
         $display("FAIL x0_after got=%h/%h exp=0", bif.read_data1, nif.read_data2);
      end
      nvec++;
      if (bif.write_count !== 16'(wcount) || nif.write_count !== 16'(wcount)) begin
         nerr++;
         $display("FAIL x0_count got=%0d/%0d exp=%0d", bif.write_count, nif.write_count, wcount);
      end
   endtask

   task automatic test_bypass();
      apply(5'd0, 5'd0, 5'd7, 64'h0, 1'b1);
      step();
      apply(5'd7, 5'd7, 5'd7, 64'hDB6D_B6DB_6DB6_DB6D, 1'b1);
      #1;
      nvec++;
      if (bif.read_data1 !== 64'hDB6D_B6DB_6DB6_DB6D ||
          bif.read_data2 !== 64'hDB6D_B6DB_6DB6_DB6D) begin
         nerr++;
         $display("FAIL bypass_on got=%h/%h exp=db6d..", bif.read_data1, bif.read_data2);
      end
      nvec++;
      if (nif.read_data1 !== 64'h0 || nif.read_data2 !== 64'h0) begin
         nerr++;
         $display("FAIL bypass_off got=%h/%h exp=0", nif.read_data1, nif.read_data2);
      end
      step();
      apply(5'd7, 5'd7, 5'd0, 64'h0, 1'b0);
      #1;
      nvec++;
      if (nif.read_data1 !== 64'hDB6D_B6DB_6DB6_DB6D ||
          nif.read_data2 !== 64'hDB6D_B6DB_6DB6_DB6D ||
          bif.read_data1 !== 64'hDB6D_B6DB_6DB6_DB6D) begin
         nerr++;
         $display("FAIL bypass_commit got=%h/%h/%h exp=db6d..",
                  nif.read_data1, nif.read_data2, bif.read_data1);
      end
   endtask

   task automatic test_reset_mid_write();
      apply(5'd9, 5'd9, 5'd9, 64'h1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if (bif.read_data1 !== 64'h0 || bif.read_data2 !== 64'h0 ||
          bif.write_count !== 16'h0) begin
         nerr++;
         $display("FAIL midrst_async got=%h/%h cnt=%0d exp=0",
                  bif.read_data1, bif.read_data2, bif.write_count);
      end
      clear_model();
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply(5'd9, 5'd9, 5'd0, 64'h0, 1'b0);
      #1;
      nvec++;
      if (bif.read_data1 !== 64'h0 || nif.read_data1 !== 64'h0) begin
         nerr++;
         $display("FAIL midrst_x9 got=%h/%h exp=0", bif.read_data1, nif.read_data1);
      end
      nvec++;
      if (bif.write_count !== 16'h0 || nif.write_count !== 16'h0) begin
         nerr++;
         $display("FAIL midrst_count got=%0d/%0d exp=0", bif.write_count, nif.write_count);
      end
   endtask

   task automatic test_random();
      logic [63:0] e;
      for (int k = 0; k < 400; k++) begin
         apply(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), {$urandom, $urandom},
               1'($urandom_range(0, 3) != 0));
         #1;
         e = exp_read(bif.rs1, 1'b1);
         nvec++;
         if (bif.read_data1 !== e) begin
            nerr++;
            $display("FAIL rand_b1 rs=%0d got=%h exp=%h", bif.rs1, bif.read_data1, e);
         end
         e = exp_read(bif.rs2, 1'b1);
         nvec++;
         if (bif.read_data2 !== e) begin
            nerr++;
            $display("FAIL rand_b2 rs=%0d got=%h exp=%h", bif.rs2, bif.read_data2, e);
         end
         e = exp_read(nif.rs1, 1'b0);
         nvec++;
         if (nif.read_data1 !== e) begin
            nerr++;
            $display("FAIL rand_n1 rs=%0d got=%h exp=%h", nif.rs1, nif.read_data1, e);
         end
         e = exp_read(nif.rs2, 1'b0);
         nvec++;
         if (nif.read_data2 !== e) begin
            nerr++;
            $display("FAIL rand_n2 rs=%0d got=%h exp=%h", nif.rs2, nif.read_data2, e);
         end
         step();
         nvec++;
         if (bif.write_count !== 16'(wcount) || nif.write_count !== 16'(wcount)) begin
            nerr++;
            $display("FAIL rand_count got=%0d/%0d exp=%0d",
                     bif.write_count, nif.write_count, wcount);
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 65540; k++) begin
         apply(5'd0, 5'd0, 5'((k % 31) + 1), {$urandom, $urandom}, 1'b1);
         step();
      end
      apply(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
      #1;
      nvec++;
      if (bif.write_count !== 16'hFFFF || nif.write_count !== 16'hFFFF ||
          wcount != 65535) begin
         nerr++;
         $display("FAIL sat_count got=%h/%h exp=ffff", bif.write_count, nif.write_count);
      end
      for (int i = 1; i < 32; i++) begin
         apply(5'(i), 5'(i), 5'd0, 64'h0, 1'b0);
         #1;
         nvec++;
         if (bif.read_data1 !== model[i] || nif.read_data2 !== model[i]) begin
            nerr++;
            $display("FAIL sat_final x%0d got=%h/%h exp=%h", i,
                     bif.read_data1, nif.read_data2, model[i]);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      clear_model();
      apply(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
      repeat (2) @(posedge clk);
      test_reset();
      test_basic();
      test_x0();
      test_bypass();
      test_reset_mid_write();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/register_file_64.md
# register_file_64

Integer register file for the sequential RISC-V core: 32 × 64-bit architectural registers (x0–x31) with two combinational read ports and one synchronous write port. It sits directly upstream of the 64-bit ALU (ADD/SUB/AND/OR/XOR/shift units) and supplies both operands A and B. It also accepts the write-back result from the ALU or memory stage.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only
---
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- rs1  input  ADDR_WIDTH  read port 1 index (operand A)
- rs2  input  ADDR_WIDTH  read port 2 index (operand B)
- rd  input  ADDR_WIDTH  write index
- write_data  input  DATA_WIDTH  write-back value
- reg_write  input  1  write enable, sampled on rising clk
- read_data1  output  DATA_WIDTH  contents of rs1 (feeds ALU A)
- read_data2  output  DATA_WIDTH  contents of rs2 (feeds ALU B)
- write_count  output  16  count of committed non-x0 writes since reset, saturating

## Operation
- Storage: 32 registers of DATA_WIDTH bits each. x0 is hardwired to zero.
- Write: on a rising clk with rst_n=1 and reg_write=1 and rd≠0, register[rd] ← write_data.
  - A write with rd=0 is discarded.
  - A discarded write does not increment write_count.
- Read: read_data1/2 are combinational functions of rs1/rs2 and the current register contents.
  - Index 0 always reads 64'h0, including under bypass.
- Bypass (BYPASS=1): if reg_write=1, rd≠0 and rs1==rd, read_data1 = write_data in the same cycle. The same rule applies to read_data2 with rs2.
  - Both ports may bypass simultaneously.
- BYPASS=0: reads reflect the stored value until the clock edge commits the write.
- write_count: increments by 1 on each committed write (rd≠0). It holds at 16'hFFFF once reached.
- Reset: rst_n=0 asynchronously clears all 32 registers and write_count to 0, independent of clk.
  - While rst_n=0, writes are ignored.
  - While rst_n=0, bypass is suppressed: outputs read 0 for all indices.
- Deassertion: the first write can commit on the first rising edge after rst_n goes high.

## Timing
- Read latency: 0 cycles, purely combinational from rs1/rs2/register state.
- Write latency: 1 cycle. The value is visible via the stored path after the rising edge where reg_write=1.
- With BYPASS=1, the value is also visible combinationally before that edge.
- Reset values: read_data1=0, read_data2=0, write_count=0, all registers=0.
- Reset mid-operation: rst_n falling with reg_write=1 aborts the pending write.
  - Outputs go to 0 without waiting for clk.
- Simultaneous read and write of the same index, BYPASS=0: the read returns the old value during the cycle and the new value after the edge.
- Back-to-back writes to the same rd: the last write wins. Each write increments write_count.
- Width rules: write_data is stored unmodified (no sign or zero extension). Index values outside 0–31 cannot occur (5-bit).

## Test plan
- Reset: assert rst_n=0 with registers preloaded -> read_data1/2=0 for rs=1..31 immediately, no clk edge required; write_count=0.
- Basic write/read: write x5=64'hFFFF_FFFF_FFFF_FFFF and x6=64'hAAAA_AAAA_AAAA_AAAA, then rs1=5, rs2=6 -> read_data1=all-ones, read_data2=64'hAAAA…AAAA (ALU OR result would be all-ones); write_count=2.
- x0 protection: reg_write=1, rd=0, write_data=64'h1 -> read x0=0 forever, write_count unchanged; same result with rs1=rs2=0 during the write (no bypass).
- Bypass: BYPASS=1, x7=64'h0, drive rd=7, rs1=7, rs2=7, write_data=64'hDB6D_B6DB_6DB6_DB6D, reg_write=1 -> both outputs show the new value before the edge. With BYPASS=0 -> both show 0 until after the edge.
- Reset mid-write: reg_write=1, rd=9, write_data=64'h1; drop rst_n before the edge, release after -> x9 reads 0, write_count=0.
- Saturation/overwrite: 65,540 writes cycling rd=1..31 -> write_count=16'hFFFF; the final value in each register equals its last write.
